// File: rtl/vga_sync_decoder.sv
// Recovers pixel/line coordinates and lock status from CRT-style active-low hsync/vsync,
// measuring line and frame totals on pixel-enable ticks.
//
// state     | meaning
// S_SEARCH  | waiting for a vsync falling edge to start measuring
// S_MEASURE | first frame: capture reference line length and frame height
// S_CHECK   | confirm the frame height repeats before declaring lock
// S_LOCKED  | timing stable; any line/frame mismatch drops back to SEARCH
module vga_sync_decoder #(
   parameter int ResolutionSize = 10
) (
   input  logic                      Clock,
   input  logic                      Reset,
   input  logic                      PixelClock,
   input  logic                      hsync,
   input  logic                      vsync,
   input  logic [ResolutionSize-1:0] hStart,
   input  logic [ResolutionSize-1:0] vStart,
   input  logic [ResolutionSize-1:0] Xresolution,
   input  logic [ResolutionSize-1:0] Yresolution,
   output logic [ResolutionSize-1:0] xpos,
   output logic [ResolutionSize-1:0] ypos,
   output logic                      ActiveVideo,
   output logic                      Locked,
   output logic                      LineStart,
   output logic                      FrameStart,
   output logic [ResolutionSize-1:0] HTotal,
   output logic [ResolutionSize-1:0] VTotal,
   output logic                      SyncError
);

   localparam int N = ResolutionSize;
   localparam logic [N-1:0] CNT_MAX = '1;
   localparam logic [N-1:0] ONE     = {{(N-1){1'b0}}, 1'b1};

   localparam logic [1:0] S_SEARCH  = 2'd0;
   localparam logic [1:0] S_MEASURE = 2'd1;
   localparam logic [1:0] S_CHECK   = 2'd2;
   localparam logic [1:0] S_LOCKED  = 2'd3;

   logic [1:0]   state;
   logic [1:0]   state_nxt;
   logic         hs_q;
   logic         vs_q;
   logic [N-1:0] hcount;
   logic [N-1:0] vcount;
   logic [N-1:0] ref_h;
   logic [N-1:0] ref_v;
   logic         have_ref;
   logic         store_ref_h;
   logic         store_ref_v;
   logic         h_bad;
   logic         h_edge;
   logic         v_edge;
   logic         h_sat_hit;
   logic         sync_err_nxt;
   logic [N-1:0] h_total_new;
   logic [N-1:0] v_total_new;
   logic [N:0]   h_end;
   logic [N:0]   v_end;
   logic         in_h;
   logic         in_v;
   logic         win;

   assign h_edge      = PixelClock & hs_q & ~hsync;
   assign v_edge      = PixelClock & vs_q & ~vsync;
   assign h_total_new = hcount + ONE;
   assign v_total_new = vcount + ONE;
   // Fires once, on the tick where the free-running line counter pins at its maximum.
   assign h_sat_hit   = PixelClock & ~h_edge & (hcount == (CNT_MAX - ONE));

   assign Locked = (state == S_LOCKED);

   always_comb begin
      state_nxt   = state;
      store_ref_h = 1'b0;
      store_ref_v = 1'b0;
      h_bad       = h_edge && (h_total_new != ref_h);
      case (state)
         S_SEARCH: begin
            if (v_edge) state_nxt = S_MEASURE;
         end
         S_MEASURE: begin
            if (have_ref && h_bad) begin
               state_nxt = S_SEARCH;
            end else begin
               if (h_edge && !have_ref) store_ref_h = 1'b1;
               if (v_edge) begin
                  store_ref_v = 1'b1;
                  state_nxt   = S_CHECK;
               end
            end
         end
         S_CHECK: begin
            if (h_bad) begin
               state_nxt = S_SEARCH;
            end else if (v_edge) begin
               if (v_total_new == ref_v) state_nxt = S_LOCKED;
               else                      store_ref_v = 1'b1;
            end
         end
         default: begin
            if (h_bad || (v_edge && (v_total_new != ref_v))) state_nxt = S_SEARCH;
         end
      endcase
      if (h_sat_hit) state_nxt = S_SEARCH;
   end

   assign sync_err_nxt = (state == S_LOCKED) && (state_nxt == S_SEARCH);

   // Window bounds carry an extra bit so start+size never wraps back into range.
   assign h_end = {1'b0, hStart} + {1'b0, Xresolution};
   assign v_end = {1'b0, vStart} + {1'b0, Yresolution};
   assign in_h  = (hcount >= hStart) && ({1'b0, hcount} < h_end);
   assign in_v  = (vcount >= vStart) && ({1'b0, vcount} < v_end);
   assign win   = in_h && in_v && (state == S_LOCKED);

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state       <= S_SEARCH;
         hs_q        <= 1'b1;
         vs_q        <= 1'b1;
         hcount      <= '0;
         vcount      <= '0;
         ref_h       <= '0;
         ref_v       <= '0;
         have_ref    <= 1'b0;
         HTotal      <= '0;
         VTotal      <= '0;
         xpos        <= '0;
         ypos        <= '0;
         ActiveVideo <= 1'b0;
         LineStart   <= 1'b0;
         FrameStart  <= 1'b0;
         SyncError   <= 1'b0;
      end else begin
         if (PixelClock) begin
            hs_q <= hsync;
            vs_q <= vsync;
            if (h_edge) begin
               HTotal <= h_total_new;
               hcount <= '0;
            end else if (hcount != CNT_MAX) begin
               hcount <= h_total_new;
            end
            if (v_edge) begin
               VTotal <= v_total_new;
               vcount <= '0;
            end else if (h_edge && (vcount != CNT_MAX)) begin
               vcount <= v_total_new;
            end
         end
         state <= state_nxt;
         if (store_ref_h) ref_h <= h_total_new;
         if (store_ref_v) ref_v <= v_total_new;
         if (state == S_SEARCH) have_ref <= 1'b0;
         else if (store_ref_h)  have_ref <= 1'b1;
         SyncError   <= sync_err_nxt;
         LineStart   <= h_edge;
         FrameStart  <= v_edge;
         ActiveVideo <= win;
         xpos        <= win ? (hcount - hStart) : '0;
         ypos        <= win ? (vcount - vStart) : '0;
      end
   end

endmodule

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 Parameter ResolutionSize, default 10, width of all counters, coordinates and measured totals.
REQ-002 Clock  input  1  system clock; all state updates on its rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 PixelClock  input  1  one-Clock-wide pixel enable; the block samples sync inputs and advances counters only on cycles where PixelClock=1 (a "tick").
REQ-005 hsync, vsync  input  1 each  active-low sync pulses from a CRT timing source.
REQ-006 hStart, vStart  input  ResolutionSize each  ticks (lines) from sync falling edge to first active pixel (line).
REQ-007 Xresolution, Yresolution  input  ResolutionSize each  active width and height.
REQ-008 xpos, ypos  output  ResolutionSize each  recovered active-video coordinates.
REQ-009 ActiveVideo  output  1  high while (xpos,ypos) is inside the active window and Locked=1.
REQ-010 Locked  output  1  timing is stable.
REQ-011 LineStart, FrameStart  output  1 each  one-Clock pulses on hsync and vsync falling-edge ticks.
REQ-012 HTotal, VTotal  output  ResolutionSize each  last measured ticks per line and lines per frame.
REQ-013 SyncError  output  1  one-Clock pulse when lock is lost.

Function
REQ-014 Each tick registers hsync/vsync; a falling edge is sample=0 with the previous sample=1; no edge is detected on non-tick cycles.
REQ-015 hcount: on an hsync edge tick, HTotal <= hcount+1 and hcount <= 0; otherwise hcount increments each tick, saturating at 2^ResolutionSize-1.
REQ-016 vcount: on a vsync edge tick, VTotal <= vcount+1 and vcount <= 0; otherwise vcount increments on each hsync edge tick, saturating.
REQ-017 If both edges fall on the same tick, vcount resets to 0 (not incremented), and HTotal and VTotal are both captured.
REQ-018 FSM states: SEARCH, MEASURE, CHECK, LOCKED; Locked=1 only in LOCKED.
REQ-019 SEARCH -> MEASURE on a vsync edge tick.
REQ-020 MEASURE: the first hsync edge stores refH; any later hsync edge whose HTotal differs from refH returns the FSM to SEARCH; a vsync edge stores refV=VTotal and moves to CHECK.
REQ-021 CHECK: HTotal is compared to refH as in MEASURE; on a vsync edge, VTotal==refV -> LOCKED, otherwise refV <= VTotal and the FSM stays in CHECK.
REQ-022 LOCKED: an HTotal!=refH or VTotal!=refV capture -> SEARCH with SyncError pulsed on the following Clock cycle.
REQ-023 From any state, hcount reaching saturation -> SEARCH; SyncError pulses only if the state was LOCKED.
REQ-024 ActiveVideo = Locked AND hStart <= hcount < hStart+Xresolution AND vStart <= vcount < vStart+Yresolution; the window sums are computed one bit wider, with no wrap.
REQ-025 xpos = hcount-hStart and ypos = vcount-vStart when ActiveVideo=1, else 0; xpos, ypos and ActiveVideo are registered, with one Clock of latency after the hcount update.
REQ-026 LineStart and FrameStart are registered pulses, asserted the Clock cycle after the edge tick, independent of Locked.

Reset
REQ-027 Reset=1 forces state SEARCH; hcount, vcount, refH, refV, HTotal, VTotal, xpos and ypos to 0; Locked, ActiveVideo, LineStart, FrameStart and SyncError to 0; sync history registers to 1.
REQ-028 Reset asserted mid-frame takes effect on that Clock edge; the block then behaves as out of power-up, and Reset has priority over PixelClock.

Verification
REQ-029 PixelClock every 4th Clock; stream with hSynch=2, hBack=1, Xres=8, hFront=1, vSynch=1, vBack=3, Yres=4, vFront=2, hStart=3, vStart=4 -> HTotal=12, VTotal=10, Locked rises at the third vsync edge, ActiveVideo covers xpos 0..7 and ypos 0..3.
REQ-030 Once locked, stretch one line to 13 ticks -> Locked=0, SyncError exactly one Clock, FSM relocks after three further clean frames.
REQ-031 Once locked, hold hsync high for 1024 ticks -> saturation, return to SEARCH, SyncError pulses once.
REQ-032 Align hsync and vsync falling edges on the same tick -> vcount=0, FrameStart and LineStart pulse in the same Clock cycle.
REQ-033 Assert Reset while locked and mid-line -> all outputs 0 on the next Clock; relock follows the REQ-029 timing.
REQ-034 Hold PixelClock=0 while toggling hsync and vsync -> no counter, edge or output changes.
